// File: rtl/issue_scheduler.sv
// Issue-queue select logic: age-matrix oldest-ready pick per functional unit,
// with registered grants, live-slot tracking and a busy counter for the last FU.
module issue_scheduler #(
  parameter int IQ_SIZE         = 16,
  parameter int NUM_FU          = 3,
  parameter int LAST_FU_LATENCY = 4,
  localparam int IDX_W          = $clog2(IQ_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    flush,
  input  logic                    alloc_valid,
  input  logic [IDX_W-1:0]        alloc_idx,
  input  logic [NUM_FU-1:0]       alloc_fu_mask,
  input  logic [IQ_SIZE-1:0]      src_ready,
  input  logic [NUM_FU-1:0]       fu_ready,
  output logic [NUM_FU-1:0]       issue_valid,
  output logic [NUM_FU*IDX_W-1:0] issue_idx,
  output logic [IQ_SIZE-1:0]      entry_valid,
  output logic                    alloc_err
);

  localparam int BUSY_W = $clog2(LAST_FU_LATENCY) + 1;

  logic [IQ_SIZE-1:0] valid;
  logic [NUM_FU-1:0]  fu_mask [IQ_SIZE];
  logic [IQ_SIZE-1:0] older   [IQ_SIZE];
  logic [BUSY_W-1:0]  busy_cnt;

  logic [IQ_SIZE-1:0] cand;
  logic [IQ_SIZE-1:0] others;
  logic [IQ_SIZE-1:0] taken;
  logic [NUM_FU-1:0]  pick_any;
  logic [IDX_W-1:0]   pick_idx [NUM_FU];
  logic               avail;
  logic               alloc_ok;
  logic               alloc_hit;
  logic [IQ_SIZE-1:0] alloc_oh;

  assign entry_valid = valid;
  assign alloc_hit   = alloc_valid & valid[alloc_idx];
  assign alloc_ok    = alloc_valid & ~valid[alloc_idx] & ~flush;
  assign alloc_oh    = alloc_ok ? (IQ_SIZE'(1) << alloc_idx) : '0;

  // Lower-numbered FUs pick first; their picks are masked out for later FUs.
  always_comb begin
    taken    = '0;
    pick_any = '0;
    cand     = '0;
    others   = '0;
    avail    = 1'b0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      pick_idx[f] = '0;
      avail = fu_ready[f] & ~stall_in & ~flush;
      if ((f == NUM_FU - 1) && (busy_cnt != '0))
        avail = 1'b0;
      for (int unsigned i = 0; i < IQ_SIZE; i++)
        cand[i] = valid[i] & src_ready[i] & fu_mask[i][f] & avail & ~taken[i];
      for (int unsigned i = 0; i < IQ_SIZE; i++) begin
        others    = cand;
        others[i] = 1'b0;
        if (cand[i] && ((others & ~older[i]) == '0)) begin
          pick_any[f] = 1'b1;
          pick_idx[f] = i[IDX_W-1:0];
        end
      end
      if (pick_any[f])
        taken[pick_idx[f]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      issue_valid <= '0;
      issue_idx   <= '0;
      busy_cnt    <= '0;
      alloc_err   <= 1'b0;
      for (int unsigned i = 0; i < IQ_SIZE; i++) begin
        fu_mask[i] <= '0;
        older[i]   <= '0;
      end
    end else if (flush) begin
      valid       <= '0;
      issue_valid <= '0;
      issue_idx   <= '0;
      busy_cnt    <= '0;
    end else begin
      valid       <= (valid & ~taken) | alloc_oh;
      issue_valid <= pick_any;
      for (int unsigned f = 0; f < NUM_FU; f++)
        issue_idx[f*IDX_W +: IDX_W] <= pick_idx[f];
      if (alloc_hit)
        alloc_err <= 1'b1;
      if (pick_any[NUM_FU-1])
        busy_cnt <= BUSY_W'(LAST_FU_LATENCY - 1);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
      // A new entry is younger than every survivor of this cycle's grants.
      if (alloc_ok) begin
        fu_mask[alloc_idx] <= alloc_fu_mask;
        older[alloc_idx]   <= '0;
        for (int unsigned j = 0; j < IQ_SIZE; j++)
          older[j][alloc_idx] <= valid[j] & ~taken[j];
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: timestamp-based reference model checked
// every cycle, plus literal expectations from the hand-worked scenarios.
module tb_issue_scheduler;

  localparam int IQ  = 16;
  localparam int NF  = 3;
  localparam int LAT = 4;
  localparam int IW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stall_in = 1'b0;
  logic           flush = 1'b0;
  logic           alloc_valid = 1'b0;
  logic [IW-1:0]  alloc_idx = '0;
  logic [NF-1:0]  alloc_fu_mask = '0;
  logic [IQ-1:0]  src_ready = '1;
  logic [NF-1:0]  fu_ready = '1;
  logic [NF-1:0]  issue_valid;
  logic [NF*IW-1:0] issue_idx;
  logic [IQ-1:0]  entry_valid;
  logic           alloc_err;

  issue_scheduler #(.IQ_SIZE(IQ), .NUM_FU(NF), .LAST_FU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_fu_mask(alloc_fu_mask),
    .src_ready(src_ready), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .entry_valid(entry_valid), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: live flags, masks, allocation timestamps (smaller = older).
  bit          mv   [IQ];
  bit [NF-1:0] mm   [IQ];
  int unsigned age  [IQ];
  int unsigned stamp = 0;
  int          busy = 0;
  bit          merr = 0;
  bit [NF-1:0]    e_iv = '0;
  bit [NF*IW-1:0] e_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [IQ-1:0] model_valid();
    logic [IQ-1:0] v;
    for (int i = 0; i < IQ; i++) v[i] = mv[i];
    return v;
  endfunction

  // One clock: predict from current inputs and model state, advance, compare.
  task automatic step();
    bit taken [IQ];
    bit av;
    int best;
    for (int i = 0; i < IQ; i++) taken[i] = 0;
    e_iv  = '0;
    e_idx = '0;
    for (int f = 0; f < NF; f++) begin
      av = fu_ready[f] && !stall_in && !flush && (f != NF - 1 || busy == 0);
      best = -1;
      for (int i = 0; i < IQ; i++)
        if (av && mv[i] && src_ready[i] && mm[i][f] && !taken[i] &&
            (best < 0 || age[i] < age[best]))
          best = i;
      if (best >= 0) begin
        e_iv[f] = 1'b1;
        e_idx[f*IW +: IW] = best[IW-1:0];
        taken[best] = 1;
      end
    end
    if (rst) begin
      for (int i = 0; i < IQ; i++) begin mv[i] = 0; mm[i] = '0; end
      busy = 0; merr = 0; e_iv = '0; e_idx = '0;
    end else if (flush) begin
      for (int i = 0; i < IQ; i++) mv[i] = 0;
      busy = 0; e_iv = '0; e_idx = '0;
    end else begin
      bit do_alloc;
      do_alloc = 0;
      if (alloc_valid) begin
        if (mv[alloc_idx]) merr = 1;
        else do_alloc = 1;
      end
      for (int i = 0; i < IQ; i++) if (taken[i]) mv[i] = 0;
      if (do_alloc) begin
        mv[alloc_idx] = 1; mm[alloc_idx] = alloc_fu_mask; age[alloc_idx] = stamp; stamp++;
      end
      if (e_iv[NF-1]) busy = LAT - 1;
      else if (busy > 0) busy--;
    end
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("issue_idx", 32'(issue_idx), 32'(e_idx));
    chk("entry_valid", 32'(entry_valid), 32'(model_valid()));
    chk("alloc_err", 32'(alloc_err), 32'(merr));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic alloc(input int idx, input logic [NF-1:0] mask);
    alloc_valid = 1'b1; alloc_idx = idx[IW-1:0]; alloc_fu_mask = mask;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_issue_valid", 32'(issue_valid), 32'h0);
    chk("rst_entry_valid", 32'(entry_valid), 32'h0);
    chk("rst_alloc_err", 32'(alloc_err), 32'h0);

    // Slot 3 then slot 5 on FU0
    alloc(3, 3'b001);
    alloc(5, 3'b001);
    chk("t1_first_iv", 32'(issue_valid), 32'h1);
    chk("t1_first_idx", 32'(issue_idx), 32'h3);
    chk("t1_live5", 32'(entry_valid), 32'h0020);
    idle(1);
    chk("t1_second_idx", 32'(issue_idx), 32'h5);
    chk("t1_empty", 32'(entry_valid), 32'h0);
    idle(1);

    // Age beats index: 9 older than 2
    src_ready = '0;
    alloc(9, 3'b011);
    alloc(2, 3'b011);
    src_ready = '1;
    idle(1);
    chk("t2_iv", 32'(issue_valid), 32'h3);
    chk("t2_idx", 32'(issue_idx), 32'h029);
    idle(1);

    // Non-pipelined FU2 spacing
    src_ready = '0;
    alloc(1, 3'b100);
    alloc(4, 3'b100);
    src_ready = '1;
    idle(1);
    chk("t3_T_iv", 32'(issue_valid), 32'h4);
    chk("t3_T_idx", 32'(issue_idx), 32'h100);
    for (int k = 1; k <= 3; k++) begin
      idle(1);
      chk("t3_busy_iv", 32'(issue_valid), 32'h0);
    end
    idle(1);
    chk("t3_T4_iv", 32'(issue_valid), 32'h4);
    chk("t3_T4_idx", 32'(issue_idx), 32'h400);
    idle(1);

    // Stall holds grants off
    src_ready = '0;
    alloc(0, 3'b001);
    alloc(7, 3'b001);
    src_ready = '1;
    stall_in = 1'b1;
    idle(1);
    chk("t4_stall1", 32'(issue_valid), 32'h0);
    idle(1);
    chk("t4_stall2", 32'(issue_valid), 32'h0);
    stall_in = 1'b0;
    idle(1);
    chk("t4_post_iv", 32'(issue_valid), 32'h1);
    chk("t4_post_idx", 32'(issue_idx), 32'h0);
    idle(1);
    chk("t4_next_idx", 32'(issue_idx), 32'h7);
    idle(1);

    // Double allocation of slot 6
    src_ready = '0;
    alloc(6, 3'b010);
    alloc(6, 3'b001);
    chk("t5_err", 32'(alloc_err), 32'h1);
    src_ready = '1;
    idle(1);
    chk("t5_iv", 32'(issue_valid), 32'h2);
    chk("t5_idx", 32'(issue_idx), 32'h060);
    idle(1);
    chk("t5_once", 32'(issue_valid), 32'h0);

    // Flush while FU2 busy, concurrent alloc dropped
    do_reset();
    src_ready = '0;
    alloc(2, 3'b100);
    alloc(3, 3'b100);
    alloc(10, 3'b100);
    src_ready = 16'h0400;
    idle(1);
    chk("t6_grant10", 32'(issue_idx), 32'hA00);
    src_ready = '1;
    flush = 1'b1; alloc_valid = 1'b1; alloc_idx = 4'd8; alloc_fu_mask = 3'b100;
    step();
    flush = 1'b0; alloc_valid = 1'b0;
    chk("t6_entry_valid", 32'(entry_valid), 32'h0);
    chk("t6_alloc_err", 32'(alloc_err), 32'h0);
    chk("t6_iv", 32'(issue_valid), 32'h0);
    alloc(0, 3'b100);
    idle(1);
    chk("t6_fresh_iv", 32'(issue_valid), 32'h4);
    chk("t6_fresh_idx", 32'(issue_idx), 32'h000);
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
